// File: rtl/dm_be_pkg.sv
// dm_be_pkg: shared depth, address-width and byte-enable codes for the data memory
package dm_be_pkg;
  localparam int DM_DEPTH = 2048;
  localparam int DM_AW = $clog2(4 * DM_DEPTH);
  typedef enum logic [3:0] {
    BE_NONE    = 4'b0000,
    BE_BYTE0   = 4'b0001,
    BE_BYTE1   = 4'b0010,
    BE_HALF_LO = 4'b0011,
    BE_BYTE2   = 4'b0100,
    BE_BYTE3   = 4'b1000,
    BE_HALF_HI = 4'b1100,
    BE_WORD    = 4'b1111
  } be_t;
endpackage

// File: rtl/dm_lane_merge.sv
// dm_lane_merge: replicates store data across lanes and flags legal byte-enable codes
module dm_lane_merge
  import dm_be_pkg::*;
(
  input  logic [3:0]  be,
  input  logic [31:0] wd,
  output logic [31:0] lane_data,
  output logic        legal
);
  always_comb begin
    legal = be inside {BE_WORD, BE_HALF_LO, BE_HALF_HI, BE_BYTE0, BE_BYTE1, BE_BYTE2, BE_BYTE3};
    lane_data = (be == BE_WORD) ? wd :
                (be == BE_HALF_LO || be == BE_HALF_HI) ? {2{wd[15:0]}} : {4{wd[7:0]}};
  end
endmodule

// File: rtl/dm_be.sv
// dm_be: byte-enabled word data memory with combinational read and registered store-reject flag
module dm_be
  import dm_be_pkg::*;
#(
  parameter int DEPTH = DM_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WE,
  input  logic [3:0]  BE,
  input  logic [31:0] Addr,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        BE_err
);
  localparam int AW = $clog2(4 * DEPTH);
  logic [31:0] mem [DEPTH];
  logic [31:0] lane_data;
  logic        legal;
  logic        in_range;
  logic [AW-3:0] idx;
  dm_lane_merge u_merge (
    .be(BE),
    .wd(WD),
    .lane_data(lane_data),
    .legal(legal)
  );
  always_comb begin
    in_range = ~|Addr[31:AW];
    idx = Addr[AW-1:2];
    RD = in_range ? mem[idx] : '0;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      BE_err <= 1'b0;
    end else begin
      BE_err <= WE & ~(legal & in_range);
      if (WE && legal && in_range)
        for (int k = 0; k < 4; k++)
          if (BE[k]) mem[idx][8*k +: 8] <= lane_data[8*k +: 8];
    end
  end
endmodule
